// File: rtl/acorn_init_ctrl.sv
// ACORN-128 initialization sequencer: latches key/IV, pulses a state clear,
// then streams 1792 message bits (key, IV, flipped K0, repeated key) with
// ca=cb=1 to the bit-serial state-update datapath under valid/ready.
module acorn_init_ctrl #(
   parameter int unsigned KEY_W      = 128,
   parameter int unsigned IV_W       = 128,
   parameter int unsigned INIT_STEPS = 1792,
   parameter int unsigned IDX_W      = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   input  logic [IV_W-1:0]  iv_in,
   input  logic             step_ready,
   output logic             state_clr,
   output logic             step_valid,
   output logic             mbit,
   output logic             ca,
   output logic             cb,
   output logic [IDX_W-1:0] step_idx,
   output logic             busy,
   output logic             done
);

   localparam int unsigned KSEL_W = $clog2(KEY_W);
   localparam int unsigned ISEL_W = $clog2(IV_W);

   // Last index of each phase; the FLIP phase is a single step after IV_LAST.
   localparam logic [IDX_W-1:0] KEY_LAST  = IDX_W'(KEY_W - 1);
   localparam logic [IDX_W-1:0] IV_LAST   = IDX_W'(KEY_W + IV_W - 1);
   localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(INIT_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      KEY  = 3'd2,
      IV   = 3'd3,
      FLIP = 3'd4,
      KREP = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   idx_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [IV_W-1:0]    iv_q, iv_d;
   logic               clr_d, valid_d, mbit_d, busy_d, done_d;

   // Next state, index, latched operands, and next values of the registered outputs.
   always_comb begin
      state_d = state;
      idx_d   = step_idx;
      key_d   = key_q;
      iv_d    = iv_q;
      clr_d   = 1'b0;
      valid_d = 1'b0;
      mbit_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d = CLR;
               idx_d   = '0;
               key_d   = key_in;
               iv_d    = iv_in;
            end
         end
         CLR: state_d = KEY;
         KEY, IV, FLIP, KREP: begin
            if (step_ready) begin
               idx_d = step_idx + IDX_W'(1);
               case (state)
                  KEY:     if (step_idx == KEY_LAST)  state_d = IV;
                  IV:      if (step_idx == IV_LAST)   state_d = FLIP;
                  FLIP:                               state_d = KREP;
                  default: if (step_idx == STEP_LAST) state_d = DONE;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are precomputed from the next state so they leave flops directly.
      case (state_d)
         CLR: begin
            clr_d  = 1'b1;
            busy_d = 1'b1;
         end
         KEY, KREP: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            mbit_d  = key_d[KSEL_W'(idx_d)];
         end
         IV: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            mbit_d  = iv_d[ISEL_W'(idx_d - IDX_W'(KEY_W))];
         end
         FLIP: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            mbit_d  = ~key_d[0];
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         step_idx   <= '0;
         key_q      <= '0;
         iv_q       <= '0;
         state_clr  <= 1'b0;
         step_valid <= 1'b0;
         mbit       <= 1'b0;
         ca         <= 1'b0;
         cb         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         step_idx   <= idx_d;
         key_q      <= key_d;
         iv_q       <= iv_d;
         state_clr  <= clr_d;
         step_valid <= valid_d;
         mbit       <= mbit_d;
         ca         <= valid_d;
         cb         <= valid_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_acorn_init_ctrl.sv
// Self-checking bench for acorn_init_ctrl: directed bit tables, random
// key/IV with random stalls against a rule-level reference, mid-run start
// and reset disturbances.
module tb_acorn_init_ctrl;

   localparam int unsigned KEY_W = 128;
   localparam int unsigned IV_W  = 128;
   localparam int unsigned STEPS = 1792;
   localparam int unsigned IDX_W = 11;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [KEY_W-1:0] key_in;
   logic [IV_W-1:0]  iv_in;
   logic             step_ready;
   logic             state_clr, step_valid, mbit, ca, cb, busy, done;
   logic [IDX_W-1:0] step_idx;

   int total = 0;
   int bad   = 0;
   bit cap [0:STEPS-1];

   typedef struct {
      int run;
      int idx;
      bit exp;
   } vec_t;

   vec_t tbl [0:15];

   acorn_init_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .iv_in      (iv_in),
      .step_ready (step_ready),
      .state_clr  (state_clr),
      .step_valid (step_valid),
      .mbit       (mbit),
      .ca         (ca),
      .cb         (cb),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Message bit of step i, straight from the initialization rules.
   function automatic bit ref_mbit(input logic [KEY_W-1:0] k, input logic [IV_W-1:0] v, input int i);
      if (i < 128)       return k[i];
      else if (i < 256)  return v[i - 128];
      else if (i == 256) return !k[0];
      else               return k[i % 128];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag, input bit exp_done);
      chk({tag, "_clr"},   32'(state_clr),  0);
      chk({tag, "_valid"}, 32'(step_valid), 0);
      chk({tag, "_busy"},  32'(busy),       0);
      chk({tag, "_ca"},    32'(ca),         0);
      chk({tag, "_cb"},    32'(cb),         0);
      chk({tag, "_done"},  32'(done),       32'(exp_done));
   endtask

   task automatic do_run(input logic [KEY_W-1:0] key, input logic [IV_W-1:0] iv,
                         input int stall_pct, input int poke_at, input int rst_at);
      int  i, cyc, stalls, guard;
      bit  rdy, poked;
      key_in = key;
      iv_in  = iv;
      start  = 1'b1;
      step_ready = 1'($urandom_range(1));
      tick();
      start = 1'b0;
      cyc   = 1;
      chk("clr_pulse", 32'(state_clr), 1);
      chk("clr_busy",  32'(busy),      1);
      chk("clr_valid", 32'(step_valid), 0);
      chk("clr_done",  32'(done),      0);
      chk("clr_idx",   32'(step_idx),  0);
      step_ready = 1'($urandom_range(1));
      tick();
      cyc++;
      i = 0; stalls = 0; poked = 0; guard = 0;
      while (i < int'(STEPS) && guard < 20000) begin
         guard++;
         chk("step_valid", 32'(step_valid), 1);
         chk("step_idx",   32'(step_idx),   32'(i));
         chk("step_mbit",  32'(mbit),       32'(ref_mbit(key, iv, i)));
         chk("step_cacb",  32'({ca, cb}),   3);
         chk("step_busy",  32'({busy, state_clr, done}), 4);
         cap[i] = mbit;
         start = 1'b0;
         if (!poked && i == poke_at) begin
            poked  = 1'b1;
            start  = 1'b1;
            key_in = ~key_in;
            iv_in  = {$urandom, $urandom, $urandom, $urandom};
         end
         if (i == rst_at) begin
            rst = 1'b0;
            #1;
            chk("rst_async_valid", 32'(step_valid), 0);
            chk("rst_async_all",   32'({state_clr, mbit, ca, cb, busy, done}), 0);
            chk("rst_async_idx",   32'(step_idx), 0);
            tick();
            chk("rst_hold_all", 32'({state_clr, step_valid, mbit, ca, cb, busy, done}), 0);
            rst = 1'b1;
            tick();
            tick();
            check_quiet("post_rst", 1'b0);
            chk("post_rst_idx", 32'(step_idx), 0);
            return;
         end
         rdy = ($urandom_range(99) >= 32'(stall_pct));
         step_ready = rdy;
         if (rdy) i++;
         else     stalls++;
         tick();
         cyc++;
      end
      start = 1'b0;
      if (i < int'(STEPS)) begin
         chk("run_timeout", 32'(i), STEPS);
      end else begin
         check_quiet("done", 1'b1);
         chk("done_idx",     32'(step_idx), STEPS);
         chk("done_latency", 32'(cyc),      32'(1794 + stalls));
      end
   endtask

   initial begin
      logic [KEY_W-1:0] k;
      logic [IV_W-1:0]  v;

      tbl = '{'{0, 0, 0}, '{0, 127, 0}, '{0, 255, 0}, '{0, 256, 1}, '{0, 257, 0}, '{0, 1791, 0},
              '{1, 0, 1}, '{1, 1, 0}, '{1, 128, 0}, '{1, 254, 0}, '{1, 255, 1}, '{1, 256, 0},
              '{1, 384, 1}, '{1, 512, 1}, '{1, 1664, 1}, '{1, 1791, 0}};

      rst = 1'b0; start = 1'b0; step_ready = 1'b0; key_in = '0; iv_in = '0;
      #1;
      chk("reset_idx", 32'(step_idx), 0);
      chk("reset_outs", 32'({state_clr, step_valid, mbit, ca, cb, busy, done}), 0);
      tick();
      tick();
      rst = 1'b1;
      step_ready = 1'b1;
      tick();
      check_quiet("idle", 1'b0);
      chk("idle_mbit", 32'(mbit), 0);

      // All-zero key/IV: only the flipped K0 step is set.
      do_run('0, '0, 0, -1, -1);
      for (int n = 0; n < 16; n++)
         if (tbl[n].run == 0) chk($sformatf("tblA_i%0d", tbl[n].idx), 32'(cap[tbl[n].idx]), 32'(tbl[n].exp));
      start = 1'b0;
      tick(); tick(); tick();
      check_quiet("done_hold", 1'b1);
      chk("done_hold_idx", 32'(step_idx), STEPS);

      // K0 and IV127 set.
      k = '0; k[0] = 1'b1;
      v = '0; v[127] = 1'b1;
      do_run(k, v, 0, -1, -1);
      for (int n = 0; n < 16; n++)
         if (tbl[n].run == 1) chk($sformatf("tblB_i%0d", tbl[n].idx), 32'(cap[tbl[n].idx]), 32'(tbl[n].exp));

      // Random operands with stalls, and an ignored start/operand change mid-run.
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      do_run(k, v, 50, 500, -1);

      // Restart from DONE with fresh operands.
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      do_run(k, v, 0, -1, -1);

      // Abort by reset partway through, then a clean run.
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      do_run(k, v, 30, -1, 1000);
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      do_run(k, v, 50, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acorn_init_ctrl.md
Name: acorn_init_ctrl

Overview:
- Sequencer for the ACORN-128 initialization phase; drives the bit-serial state update datapath for 1792 steps.
- Latches key and IV on start and issues a one-cycle state-clear.
- Each step presents the message bit m_i and control bits ca_i and cb_i under a valid/ready handshake.
- Asserts done when initialization completes so the encryption phase can take over the 293-bit state.

Parameters:
- KEY_W, 128, key width in bits.
- IV_W, 128, IV width in bits.
- INIT_STEPS, 1792, total initialization steps.
- IDX_W, 11, width of the step index (covers 0..INIT_STEPS-1).

Ports:
- clk  in  1  system clock; all registers on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request initialization; sampled only in IDLE or DONE.
- key_in  in  KEY_W  key; bit K_j = key_in[j].
- iv_in  in  IV_W  IV; bit IV_j = iv_in[j].
- step_ready  in  1  datapath accepts the current step this cycle.
- state_clr  out  1  one-cycle pulse: datapath zeroes its 293-bit state.
- step_valid  out  1  mbit, ca and cb are valid for step step_idx.
- mbit  out  1  message bit m_i for the current step.
- ca  out  1  control bit ca_i; constant 1 during init.
- cb  out  1  control bit cb_i; constant 1 during init.
- step_idx  out  IDX_W  current step index i.
- busy  out  1  high from start acceptance until completion.
- done  out  1  level; high from completion until the next accepted start.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE.
  - state_clr, step_valid, mbit, busy, done = 0.
  - ca, cb = 0.
  - step_idx = 0.
  - Latched key and IV = 0.
  - Reset mid-run aborts immediately. No done is issued; the next start restarts from step 0.
- FSM states: IDLE, CLR, KEY, IV, FLIP, KREP, DONE.
- Start acceptance:
  - In IDLE or DONE with start=1 at edge T: latch key_in and iv_in, clear step_idx and done, go to CLR.
  - start in any other state is ignored; key_in and iv_in changes are ignored after latching.
- CLR: state_clr=1 and busy=1 for exactly one cycle (T+1), step_valid=0. Then go to KEY.
- Step states (KEY, IV, FLIP, KREP):
  - step_valid=1, busy=1, ca=1, cb=1.
  - A step completes on any edge with step_valid and step_ready both 1. step_idx then increments.
  - While step_ready=0, all outputs hold stable.
- Message bit and transitions per index i:
  - KEY, i=0..127: mbit = K_i. On completing i=127, go to IV.
  - IV, i=128..255: mbit = IV_(i-128). On completing i=255, go to FLIP.
  - FLIP, i=256: mbit = K_0 XOR 1. On completion, go to KREP.
  - KREP, i=257..1791: mbit = K_(i mod 128). On completing i=1791, go to DONE.
- mbit, ca, cb and step_idx are functions of registered state only. There is no combinational path from step_ready or start to any output.
- DONE: done=1, busy=0, step_valid=0, ca=cb=0. step_idx holds 1792 (wraps within IDX_W: 1792 = 0x700, fits in 11 bits).
- Latency with step_ready tied high:
  - start sampled at T.
  - state_clr in cycle T+1.
  - Steps in cycles T+2..T+1793.
  - done high from T+1794.
- Stalls: each cycle with step_ready=0 during a step state adds exactly one cycle of latency.
- Restart: start in DONE behaves exactly as in IDLE.
- Simultaneous events: step_ready is don't-care outside the step states. rst dominates all other inputs.

Test Plan:
- Key=0, IV=0, step_ready=1, start pulse -> state_clr at T+1 only.
  - mbit=0 for i=0..255, mbit=1 at i=256, mbit=0 for i=257..1791.
  - 1792 valid steps; done at T+1794.
- Key=128'h1, IV=128'h8000...0 -> mbit=1 at i=0 and i=255.
  - mbit=0 at i=256 (K_0=1 flipped).
  - mbit=1 at i=384, 512, ..., 1664; 0 elsewhere.
- Random key and IV; step_ready toggling with 50% random stalls -> captured mbit stream matches a reference model bit for bit.
  - Outputs stable during stalls; done latency = 1794 + stall count.
- Change key_in and iv_in and pulse start at i=500 -> stream unaffected, run completes normally.
  - Then start again in DONE -> new key and IV used; done drops at T+1.
- Assert rst at i=1000, release, then start -> all outputs at reset values during reset; fresh run from i=0 with a new state_clr.
- ca and cb check -> both 1 on every valid step and 0 in IDLE and DONE.
